// File: rtl/busca_instrucao.sv
// ============================================================================
// busca_instrucao : instruction fetch between PC, instruction memory and decode
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module busca_instrucao #(
  parameter int LARG_END   = 16,
  parameter int LARG_INSTR = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LARG_END-1:0]   endAtual,
  output logic                  stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [LARG_END-1:0]   mem_end,
  input  logic                  mem_ack,
  input  logic [LARG_INSTR-1:0] mem_dado,
  output logic [LARG_INSTR-1:0] instr,
  output logic [LARG_END-1:0]   instr_end,
  output logic                  instr_valido,
  input  logic                  dec_pronto
);

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    PEDIDO   = 2'd1,
    RETIDO   = 2'd2,
    DESCARTA = 2'd3
  } estado_t;

  estado_t               estado_q;
  logic                  mem_req_q;
  logic [LARG_END-1:0]   mem_end_q;
  logic [LARG_INSTR-1:0] instr_q;
  logic [LARG_END-1:0]   instr_end_q;
  logic                  instr_valido_q;
  logic [LARG_INSTR-1:0] buffer_q;
  logic                  slot_livre;

  assign slot_livre   = !instr_valido_q || dec_pronto;
  assign mem_req      = mem_req_q;
  assign mem_end      = mem_end_q;
  assign instr        = instr_q;
  assign instr_end    = instr_end_q;
  assign instr_valido = instr_valido_q;

  // The PC may only advance when a fetched word has a home (or on redirect).
  always_comb begin
    stall = 1'b1;
    if (reset) begin
      stall = 1'b1;
    end else if (flush) begin
      stall = 1'b0;
    end else begin
      case (estado_q)
        PEDIDO:  stall = !(mem_ack && slot_livre);
        RETIDO:  stall = !dec_pronto;
        default: stall = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= INICIO;
      mem_req_q      <= 1'b0;
      mem_end_q      <= '0;
      instr_q        <= '0;
      instr_end_q    <= '0;
      instr_valido_q <= 1'b0;
      buffer_q       <= '0;
    end else begin
      if (dec_pronto) begin
        instr_valido_q <= 1'b0;
      end
      if (flush) begin
        instr_valido_q <= 1'b0;
        // An outstanding request must still be retired before a new one issues.
        case (estado_q)
          PEDIDO, DESCARTA: begin
            if (mem_ack) begin
              estado_q  <= INICIO;
              mem_req_q <= 1'b0;
            end else begin
              estado_q  <= DESCARTA;
            end
          end
          default: begin
            estado_q  <= INICIO;
            mem_req_q <= 1'b0;
          end
        endcase
      end else begin
        case (estado_q)
          INICIO: begin
            mem_end_q <= endAtual;
            mem_req_q <= 1'b1;
            estado_q  <= PEDIDO;
          end
          PEDIDO: begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              if (slot_livre) begin
                instr_q        <= mem_dado;
                instr_end_q    <= mem_end_q;
                instr_valido_q <= 1'b1;
                estado_q       <= INICIO;
              end else begin
                buffer_q <= mem_dado;
                estado_q <= RETIDO;
              end
            end
          end
          RETIDO: begin
            if (dec_pronto) begin
              instr_q        <= buffer_q;
              instr_end_q    <= mem_end_q;
              instr_valido_q <= 1'b1;
              estado_q       <= INICIO;
            end
          end
          DESCARTA: begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              estado_q  <= INICIO;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_busca_instrucao.sv
// ============================================================================
// tb_busca_instrucao : scoreboard bench with PC/memory models for busca_instrucao
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_busca_instrucao;

  logic        clock;
  logic        reset;
  logic [15:0] endAtual;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_end;
  logic        mem_ack;
  logic [15:0] mem_dado;
  logic [15:0] instr;
  logic [15:0] instr_end;
  logic        instr_valido;
  logic        dec_pronto;

  busca_instrucao #(.LARG_END(16), .LARG_INSTR(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .endAtual     (endAtual),
    .stall        (stall),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_end      (mem_end),
    .mem_ack      (mem_ack),
    .mem_dado     (mem_dado),
    .instr        (instr),
    .instr_end    (instr_end),
    .instr_valido (instr_valido),
    .dec_pronto   (dec_pronto)
  );

  int          checks   = 0;
  int          failures = 0;
  int          n_deliv  = 0;
  logic [15:0] mem [65536];
  logic [31:0] exp_q [$];
  logic [15:0] pc;
  logic [15:0] target;
  int          fixed_delay;
  bit          stray_en;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // PC model: advances (or redirects) whenever stall is low; every advance
  // without flush means the word at the current address is owed to decode.
  initial begin
    pc = 16'h0002;
    endAtual = pc;
    forever begin
      @(negedge clock);
      endAtual = pc;
      #4;
      if (!reset && stall == 1'b0) begin
        if (flush) begin
          pc = target;
          exp_q.delete();
        end else begin
          exp_q.push_back({mem[endAtual], endAtual});
          pc = endAtual + 16'd1;
        end
      end
    end
  end

  // Memory model: ack after fixed or random wait, stray acks while idle.
  initial begin
    int cnt;
    bit busy;
    cnt = 0;
    busy = 1'b0;
    mem_ack = 1'b0;
    mem_dado = 16'h0;
    forever begin
      @(negedge clock);
      mem_ack  = 1'b0;
      mem_dado = 16'($urandom);
      if (!reset && mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
        end
        if (cnt == 0) begin
          mem_ack  = 1'b1;
          mem_dado = mem[mem_end];
          busy     = 1'b0;
        end else begin
          cnt--;
        end
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
      end
    end
  end

  // Monitor: compares every word decode accepts against the scoreboard.
  initial begin
    logic        prev_req;
    logic [15:0] prev_end;
    logic [31:0] e;
    prev_req = 1'b0;
    prev_end = 16'h0;
    forever begin
      @(negedge clock);
      #3;
      if (!reset) begin
        if (prev_req && mem_req) check("mem_end_stable", 32'(mem_end), 32'(prev_end));
        if (instr_valido && dec_pronto && !flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_instr: actual=%h@%h required=none (t=%0t)", instr, instr_end, $time);
          end else begin
            e = exp_q.pop_front();
            check("sb_instr", 32'(instr), 32'(e[31:16]));
            check("sb_instr_end", 32'(instr_end), 32'(e[15:0]));
            n_deliv++;
          end
        end
        prev_req = mem_req;
        prev_end = mem_end;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[16'h0002] = 16'h1234;
    mem[16'h0006] = 16'hA5A5;
    mem[16'h0007] = 16'hBEEF;
    mem[16'h0008] = 16'hDEAD;
    mem[16'h0041] = 16'hDEAD;
    mem[16'h0061] = 16'hDEAD;
    reset = 1'b1;
    flush = 1'b0;
    dec_pronto = 1'b1;
    target = 16'h0;
    fixed_delay = 0;
    stray_en = 1'b0;

    // Reset hold
    @(negedge clock);
    @(negedge clock); #4;
    check("rst_stall", 32'(stall), 1);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_end", 32'(mem_end), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instr_end", 32'(instr_end), 0);
    check("rst_valido", 32'(instr_valido), 0);
    @(negedge clock); reset = 1'b0; #4;

    // Zero-wait fetches, one instruction per two cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #4;
      check("zw_ack_stall", 32'(stall), 0);
      check("zw_mem_req", 32'(mem_req), 1);
      check("zw_mem_end", 32'(mem_end), 32'(16'h0002 + k));
      @(negedge clock); #4;
      check("zw_instr", 32'(instr), 32'(mem[16'h0002 + k]));
      check("zw_instr_end", 32'(instr_end), 32'(16'h0002 + k));
      check("zw_valido", 32'(instr_valido), 1);
      check("zw_req_idle", 32'(mem_req), 0);
    end
    fixed_delay = 3;

    // Three wait states
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #4;
      check("ws_mem_req", 32'(mem_req), 1);
      check("ws_stall", 32'(stall), 1);
      check("ws_mem_end", 32'(mem_end), 32'h0005);
    end
    @(negedge clock); #4;
    check("ws_ack_stall", 32'(stall), 0);
    fixed_delay = 0;
    @(negedge clock); #4;
    check("ws_instr", 32'(instr), 32'(mem[16'h0005]));
    check("ws_instr_end", 32'(instr_end), 32'h0005);
    check("ws_valido", 32'(instr_valido), 1);

    // Decode backpressure: BEEF must wait in the buffer
    @(negedge clock); dec_pronto = 1'b0; #4;
    check("ws_single_pulse", 32'(instr_valido), 0);
    check("bp_first_stall", 32'(stall), 0);
    @(negedge clock); #4;
    check("bp_first_instr", 32'(instr), 32'hA5A5);
    check("bp_first_valido", 32'(instr_valido), 1);
    @(negedge clock); #4;
    check("bp_ack_stall", 32'(stall), 1);
    check("bp_ack_instr", 32'(instr), 32'hA5A5);
    @(negedge clock); #4;
    check("bp_ret_stall", 32'(stall), 1);
    check("bp_ret_mem_req", 32'(mem_req), 0);
    check("bp_ret_instr", 32'(instr), 32'hA5A5);
    check("bp_ret_valido", 32'(instr_valido), 1);
    @(negedge clock); dec_pronto = 1'b1; #4;
    check("bp_rel_stall", 32'(stall), 0);
    @(negedge clock); #4;
    check("bp_rel_instr", 32'(instr), 32'hBEEF);
    check("bp_rel_instr_end", 32'(instr_end), 32'h0007);
    check("bp_rel_valido", 32'(instr_valido), 1);
    fixed_delay = 3;

    // Flush mid-request; the late DEAD must be discarded
    @(negedge clock); flush = 1'b1; target = 16'h0040; #4;
    check("fl_stall", 32'(stall), 0);
    @(negedge clock); flush = 1'b0; #4;
    check("fl_valido", 32'(instr_valido), 0);
    check("fl_mem_req", 32'(mem_req), 1);
    check("fl_mem_end", 32'(mem_end), 32'h0008);
    @(negedge clock); #4;
    check("fl_mem_req_hold", 32'(mem_req), 1);
    @(negedge clock); #4;
    check("fl_late_ack_stall", 32'(stall), 1);
    fixed_delay = 0;
    @(negedge clock); #4;
    check("fl_idle_req", 32'(mem_req), 0);
    check("fl_no_dead", 32'(instr_valido), 0);
    @(negedge clock); #4;
    check("fl_new_end", 32'(mem_end), 32'h0040);
    check("fl_new_stall", 32'(stall), 0);
    @(negedge clock); #4;
    check("fl_new_instr", 32'(instr), 32'(mem[16'h0040]));
    check("fl_new_instr_end", 32'(instr_end), 32'h0040);

    // Flush together with ack
    @(negedge clock); flush = 1'b1; target = 16'h0060; #4;
    check("fa_stall", 32'(stall), 0);
    @(negedge clock); flush = 1'b0; #4;
    check("fa_valido", 32'(instr_valido), 0);
    check("fa_mem_req", 32'(mem_req), 0);
    @(negedge clock); #4;
    check("fa_new_end", 32'(mem_end), 32'h0060);
    check("fa_new_stall", 32'(stall), 0);

    // Flush while a word is held in the buffer
    @(negedge clock); dec_pronto = 1'b0; #4;
    check("fr_instr", 32'(instr), 32'(mem[16'h0060]));
    check("fr_valido", 32'(instr_valido), 1);
    @(negedge clock); #4;
    check("fr_ack_stall", 32'(stall), 1);
    @(negedge clock); flush = 1'b1; target = 16'h0080; #4;
    check("fr_stall", 32'(stall), 0);
    check("fr_ret_mem_req", 32'(mem_req), 0);
    @(negedge clock); flush = 1'b0; dec_pronto = 1'b1; #4;
    check("fr_valido_drop", 32'(instr_valido), 0);
    check("fr_mem_req", 32'(mem_req), 0);
    @(negedge clock); #4;
    check("fr_new_end", 32'(mem_end), 32'h0080);
    check("fr_new_stall", 32'(stall), 0);
    @(negedge clock); #4;
    check("fr_new_instr", 32'(instr), 32'(mem[16'h0080]));
    check("fr_new_instr_end", 32'(instr_end), 32'h0080);

    // Random traffic against the PC/memory scoreboard
    fixed_delay = -1;
    stray_en = 1'b1;
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      dec_pronto = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 31) == 0);
      if (flush) target = 16'($urandom);
    end
    @(negedge clock); flush = 1'b0; dec_pronto = 1'b1;
    repeat (20) @(negedge clock);
    #4;
    check("drain_queue", 32'(exp_q.size() <= 1), 1);
    check("liveness", 32'(n_deliv > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction-fetch responder on the far side of the PC interface. It consumes the PC's current address (endAtual), fetches the instruction word from instruction memory over a req/ack handshake, and presents it to decode with valid/ready flow control. It drives the PC's stall input so the PC advances only when a fetched word has been accepted, and it discards in-flight fetches on a branch flush.

Parameters:
LARG_END, 16, address width (endAtual, mem_end, instr_end)
LARG_INSTR, 16, instruction word width (mem_dado, instr, internal buffer)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
endAtual  in  LARG_END  current address from PC
stall  out  1  to PC; 0 = PC loads novoEnd on this edge
flush  in  1  branch redirect; discard in-flight/held fetch
mem_req  out  1  request to instruction memory
mem_end  out  LARG_END  address to instruction memory
mem_ack  in  1  memory response strobe, 1 cycle, data valid with it
mem_dado  in  LARG_INSTR  instruction word from memory
instr  out  LARG_INSTR  instruction to decode
instr_end  out  LARG_END  address of instr
instr_valido  out  1  instr/instr_end valid
dec_pronto  in  1  decode accepts instr this cycle

Behaviour:
- One clock (clock); reset synchronous, active-high; reset has the highest priority.
- Reset values: state INICIO; mem_req=0, mem_end=0, instr=0, instr_end=0, instr_valido=0, buffer=0. During reset, stall=1.
- slot_livre = !instr_valido || dec_pronto.
- stall is combinational. It is 0 only when one of these holds:
  - state PEDIDO, mem_ack=1 and slot_livre=1.
  - state RETIDO and dec_pronto=1.
  - flush=1 (PC takes the redirect target).
  - In every other case stall=1.
- mem_req is a registered/state-decoded output: 1 in PEDIDO and DESCARTA, 0 otherwise. mem_end is held stable while mem_req=1.
- States:
  - INICIO: mem_end<=endAtual; go to PEDIDO.
  - PEDIDO: wait for mem_ack.
    - mem_ack=1 and slot_livre=1: instr<=mem_dado, instr_end<=mem_end, instr_valido<=1; go to INICIO.
    - mem_ack=1 and slot_livre=0: buffer<=mem_dado; go to RETIDO.
    - mem_ack=0: stay in PEDIDO.
  - RETIDO: mem_req=0.
    - dec_pronto=1: instr<=buffer, instr_end<=mem_end, instr_valido<=1; go to INICIO.
    - Otherwise stay in RETIDO.
  - DESCARTA: request still outstanding, mem_req=1; on mem_ack, drop the data and go to INICIO.
- instr_valido clears when dec_pronto=1 and no new word loads that edge. instr and instr_end hold their value while instr_valido=1 and dec_pronto=0.
- Latency:
  - Zero-wait memory (ack in the first PEDIDO cycle): address latched at edge N, instr_valido=1 after edge N+1.
  - Steady-state throughput is one instruction per 2 cycles.
- Flush (priority below reset, above everything else):
  - instr_valido<=0 and stall=0 that cycle.
  - INICIO goes to INICIO.
  - RETIDO goes to INICIO; buffer is dropped.
  - PEDIDO with mem_ack=1 goes to INICIO; data is dropped.
  - PEDIDO with mem_ack=0 goes to DESCARTA.
  - DESCARTA stays in DESCARTA, or goes to INICIO if mem_ack=1.
- Never issue a new request while one is outstanding. A mem_ack outside PEDIDO/DESCARTA is ignored.
- An address wraps naturally at 16'hFFFF. No special handling; the block does not compute addresses.

Test Plan:
- Reset and hold:
  - Stimulus: reset=1 for 2 cycles with mem_ack=0.
  - Required: all outputs 0 except stall=1; after release, mem_req=1 and mem_end=endAtual one cycle later.
- Zero-wait fetch:
  - Stimulus: endAtual=16'h0002, memory acks in the first PEDIDO cycle with 16'h1234, dec_pronto=1.
  - Required: stall=0 in the ack cycle; next cycle instr=16'h1234, instr_end=16'h0002, instr_valido=1.
  - Repeat for 16'h0003 and 16'h0004 to confirm one instruction per 2 cycles.
- Wait states:
  - Stimulus: ack delayed 3 cycles.
  - Required: mem_req=1, stall=1 and mem_end stable for 3 cycles; exactly one instruction delivered.
- Decode backpressure:
  - Stimulus: dec_pronto=0 when an ack with 16'hBEEF arrives while instr_valido=1.
  - Required: state RETIDO, stall=1, instr unchanged.
  - Then raise dec_pronto: stall=0 that cycle; next cycle instr=16'hBEEF.
- Flush mid-request:
  - Stimulus: flush in PEDIDO with no ack.
  - Required: stall=0 and instr_valido=0 next cycle; mem_req stays 1 until a late ack with 16'hDEAD, which never appears on instr; the next fetch uses the new endAtual=16'h0040.
- Flush with simultaneous ack, and flush in RETIDO:
  - Required: data dropped in both cases; state INICIO next cycle; no instr_valido pulse.
